// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with almost-full/almost-empty flags and optional first-word-fall-through read.
// Latency: a write is visible one cycle later; FWFT=0 returns the popped word one edge after an accepted rd_en.
// Backpressure: writes while full and reads while empty are dropped and reported by overflow/underflow pulses.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH-1:0]              data_in,
    input  logic                               wr_en,
    input  logic                               rd_en,
    output logic [DATA_WIDTH-1:0]              data_out,
    output logic                               rd_valid,
    output logic                               wr_ack,
    output logic                               overflow,
    output logic                               underflow,
    output logic                               full,
    output logic                               empty,
    output logic                               almostfull,
    output logic                               almostempty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr_nxt;
    logic [PW-1:0]         rd_ptr_nxt;
    logic                  wr_acc;
    logic                  rd_acc;

    assign full        = (count == CW'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign almostfull  = !full && (count >= CW'(AF_LEVEL));
    assign almostempty = !empty && (count <= CW'(AE_LEVEL));

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    assign wr_ptr_nxt = (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    assign rd_ptr_nxt = (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_acc;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            if (wr_acc) wr_ptr <= wr_ptr_nxt;
            if (rd_acc) rd_ptr <= rd_ptr_nxt;
            if (wr_acc && !rd_acc)
                count <= count + CW'(1);
            else if (rd_acc && !wr_acc)
                count <= count - CW'(1);
        end
    end

    // Storage is deliberately not reset; reset still blocks a coincident write.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst)
            mem[wr_ptr] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem[rd_ptr];
            assign rd_valid = !empty;
        end else begin : g_std
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_out <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc)
                        data_out <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Drives a registered-read and an FWFT FIFO (both depth 6) with identical stimulus against a queue model.
module tb_fifo_sync_param;
    localparam int DW    = 16;
    localparam int DEPTH = 6;
    localparam int AF    = DEPTH - 1;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_rv, s_ack, s_ovf, s_unf, s_full, s_empty, s_af, s_ae;
    logic          f_rv, f_ack, f_ovf, f_unf, f_full, f_empty, f_af, f_ae;
    logic [2:0]    s_cnt, f_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] last_dout;
    bit            e_ack, e_ovf, e_unf, e_rv;

    always #5 clk = ~clk;

    fifo_sync_param #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(s_dout), .rd_valid(s_rv), .wr_ack(s_ack), .overflow(s_ovf), .underflow(s_unf),
        .full(s_full), .empty(s_empty), .almostfull(s_af), .almostempty(s_ae), .count(s_cnt)
    );

    fifo_sync_param #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(f_dout), .rd_valid(f_rv), .wr_ack(f_ack), .overflow(f_ovf), .underflow(f_unf),
        .full(f_full), .empty(f_empty), .almostfull(f_af), .almostempty(f_ae), .count(f_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("std_count",  32'(s_cnt),   32'(n));
        chk("std_full",   32'(s_full),  32'(n == DEPTH));
        chk("std_empty",  32'(s_empty), 32'(n == 0));
        chk("std_af",     32'(s_af),    32'(n >= AF && n != DEPTH));
        chk("std_ae",     32'(s_ae),    32'(n <= AE && n != 0));
        chk("std_wr_ack", 32'(s_ack),   32'(e_ack));
        chk("std_ovf",    32'(s_ovf),   32'(e_ovf));
        chk("std_unf",    32'(s_unf),   32'(e_unf));
        chk("std_rv",     32'(s_rv),    32'(e_rv));
        chk("std_dout",   32'(s_dout),  32'(last_dout));
        chk("fwft_count", 32'(f_cnt),   32'(n));
        chk("fwft_ack",   32'(f_ack),   32'(e_ack));
        chk("fwft_ovf",   32'(f_ovf),   32'(e_ovf));
        chk("fwft_unf",   32'(f_unf),   32'(e_unf));
        chk("fwft_rv",    32'(f_rv),    32'(n != 0));
        if (n != 0)
            chk("fwft_head", 32'(f_dout), 32'(q[0]));
    endtask

    // One clock of stimulus; the model decides acceptance from occupancy before the edge.
    task automatic step(input bit r, input bit w, input bit rd, input logic [DW-1:0] d);
        bit wa, ra;
        logic [DW-1:0] popped;
        @(negedge clk);
        rst = r; wr_en = w; rd_en = rd; data_in = d;
        wa = w && (q.size() < DEPTH);
        ra = rd && (q.size() > 0);
        popped = ra ? q[0] : '0;
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            last_dout = '0;
            e_ack = 0; e_ovf = 0; e_unf = 0; e_rv = 0;
        end else begin
            if (ra) begin
                void'(q.pop_front());
                last_dout = popped;
            end
            if (wa) q.push_back(d);
            e_ack = wa;
            e_ovf = w && !wa;
            e_unf = rd && !ra;
            e_rv  = ra;
        end
        check_all();
    endtask

    initial begin
        last_dout = '0;
        e_ack = 0; e_ovf = 0; e_unf = 0; e_rv = 0;

        // Reset then idle
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);

        // Fill 1..6, then an overflowing seventh write
        for (int i = 1; i <= 7; i++) step(0, 1, 0, DW'(i));
        // Drain six in order, then one underflowing read
        for (int i = 0; i < 7; i++) step(0, 0, 1, '0);

        // Pointer wrap: write 4, read 4, write 4 more, read back
        for (int i = 1; i <= 4; i++) step(0, 1, 0, DW'(i));
        for (int i = 0; i < 4; i++)  step(0, 0, 1, '0);
        for (int i = 5; i <= 8; i++) step(0, 1, 0, DW'(i));
        for (int i = 0; i < 4; i++)  step(0, 0, 1, '0);

        // Simultaneous ops at full, empty, and mid-level
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, DW'(16'h0100 + i));
        step(0, 1, 1, 16'h0AAA);
        for (int i = 0; i < 5; i++) step(0, 0, 1, '0);
        step(0, 1, 1, 16'h0BBB);
        step(0, 1, 0, 16'h0CCC);
        step(0, 1, 0, 16'h0DDD);
        step(0, 1, 1, 16'h0EEE);

        // FWFT presentation of a single word
        step(1, 0, 0, '0);
        step(0, 1, 0, 16'hBEEF);
        step(0, 0, 1, '0);

        // Reset wins over coincident write/read at count 4
        for (int i = 0; i < 4; i++) step(0, 1, 0, DW'(16'h0200 + i));
        step(1, 1, 1, 16'h0F0F);
        step(0, 0, 0, '0);

        // Randomized traffic with an occasional reset
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) != 0), DW'($urandom_range(0, 65535)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
